gemm_tile_sequencer: RTL and testbench

- Parametrised successor to the single-pass GEMM top-level sequencing. Walks an (m_tiles × n_tiles) grid of I×J output tiles over a shared K depth.
- Per tile it:
  - generates ifmaps/filters SRAM read addresses;
  - skews the read vectors into systolic-array edge inputs (west lane r delayed r cycles, north lane c delayed c cycles);
  - flushes the array with zeros;
  - reports tile completion.
- Sits between the two operand SRAMs and systolic_array. Replaces the fixed control_unit path with multi-tile, handshaked operation.

---
 rtl/gemm_tile_sequencer_pkg.sv | 21 ++
 rtl/gemm_tile_sequencer_skew_line.sv | 28 ++
 rtl/gemm_tile_sequencer.sv | 171 +++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared types for the GEMM tile sequencer.
// FSM encoding and the per-tile cycle count helper.
package gemm_tile_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_TDONE
    } state_t;

    function automatic int unsigned tile_period(
        input int unsigned k,
        input int unsigned i,
        input int unsigned j
    );
        return k + i + j + 1;
    endfunction

endpackage

// File: rtl/gemm_tile_sequencer_skew_line.sv
// Fixed-depth operand delay line for one systolic edge lane.
// Cleared asynchronously with the sequencer reset.
module skew_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++)
                stage[s] <= '0;
        end else begin
            stage[0] <= d;
            for (int s = 1; s < DEPTH; s++)
                stage[s] <= stage[s-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Multi-tile GEMM sequencer: SRAM addressing, edge skew,
// array flush and tile/job completion handshakes.
module gemm_tile_sequencer
    import gemm_tile_sequencer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int I          = 4,
    parameter int J          = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      k,
    input  logic [WIDTH-1:0]      m_tiles,
    input  logic [WIDTH-1:0]      n_tiles,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] ifmaps_addr,
    output logic [ADDR_WIDTH-1:0] filters_addr,
    input  logic [I*WIDTH-1:0]    ifmaps_dout,
    input  logic [J*WIDTH-1:0]    filters_dout,
    output logic [I*WIDTH-1:0]    in_west,
    output logic [J*WIDTH-1:0]    in_north,
    output logic                  feed_valid,
    output logic                  acc_clear,
    output logic                  tile_done,
    output logic [WIDTH-1:0]      tile_row,
    output logic [WIDTH-1:0]      tile_col
);

    // FLUSH spans I+J-1 cycles: counter runs 0..I+J-2
    localparam logic [WIDTH-1:0] FLUSH_LAST =
        WIDTH'(tile_period(0, I, J) - 3);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t state, state_nx;

    logic [WIDTH-1:0]      k_q, m_q, n_q;
    logic [WIDTH-1:0]      tm, tn, cnt;
    logic [WIDTH-1:0]      kk_rd;
    logic                  zdone_q;
    logic [ADDR_WIDTH-1:0] ia_q, fa_q;
    logic [2*WIDTH-1:0]    ia_full, fa_full;
    logic                  cfg_zero, tn_wrap, last_tile;
    logic [I*WIDTH-1:0]    west_src;
    logic [J*WIDTH-1:0]    north_src;

    assign cfg_zero  = (k == '0) || (m_tiles == '0) || (n_tiles == '0);
    assign tn_wrap   = (tn == n_q - ONE);
    assign last_tile = tn_wrap && (tm == m_q - ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b1;
        done       = zdone_q;
        rd_en      = 1'b0;
        feed_valid = 1'b0;
        acc_clear  = 1'b0;
        tile_done  = 1'b0;
        kk_rd      = cnt;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !cfg_zero) state_nx = S_CLEAR;
            end
            S_CLEAR: begin
                acc_clear = 1'b1;
                rd_en     = 1'b1;
                kk_rd     = '0;
                state_nx  = S_FEED;
            end
            S_FEED: begin
                feed_valid = 1'b1;
                rd_en      = (cnt < k_q);
                if (cnt == k_q) state_nx = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt == FLUSH_LAST) state_nx = S_TDONE;
            end
            S_TDONE: begin
                tile_done = 1'b1;
                done      = last_tile;
                state_nx  = last_tile ? S_IDLE : S_CLEAR;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            m_q     <= '0;
            n_q     <= '0;
            tm      <= '0;
            tn      <= '0;
            cnt     <= '0;
            zdone_q <= 1'b0;
            ia_q    <= '0;
            fa_q    <= '0;
        end else begin
            zdone_q <= (state == S_IDLE) && start && cfg_zero;
            if (rd_en) begin
                ia_q <= ifmaps_addr;
                fa_q <= filters_addr;
            end
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        k_q <= k;
                        m_q <= m_tiles;
                        n_q <= n_tiles;
                        tm  <= '0;
                        tn  <= '0;
                    end
                end
                S_CLEAR: cnt <= ONE;
                S_FEED:  cnt <= (cnt == k_q) ? '0 : cnt + ONE;
                S_FLUSH: cnt <= cnt + ONE;
                S_TDONE: begin
                    tn <= tn_wrap ? '0 : tn + ONE;
                    if (tn_wrap) tm <= tm + ONE;
                end
                default: ;
            endcase
        end
    end

    // full-width products, silently wrapped to the SRAM address width
    assign ia_full = {{WIDTH{1'b0}}, tm} * {{WIDTH{1'b0}}, k_q}
                   + {{WIDTH{1'b0}}, kk_rd};
    assign fa_full = {{WIDTH{1'b0}}, tn} * {{WIDTH{1'b0}}, k_q}
                   + {{WIDTH{1'b0}}, kk_rd};

    assign ifmaps_addr  = rd_en ? ADDR_WIDTH'(ia_full) : ia_q;
    assign filters_addr = rd_en ? ADDR_WIDTH'(fa_full) : fa_q;

    assign tile_row = tile_done ? tm : '0;
    assign tile_col = tile_done ? tn : '0;

    assign west_src  = feed_valid ? ifmaps_dout  : '0;
    assign north_src = feed_valid ? filters_dout : '0;

    assign in_west[WIDTH-1:0]  = west_src[WIDTH-1:0];
    assign in_north[WIDTH-1:0] = north_src[WIDTH-1:0];

    for (genvar r = 1; r < I; r++) begin : g_west
        skew_line #(.WIDTH(WIDTH), .DEPTH(r)) u_skew (
            .clk (clk),
            .rst (rst),
            .d   (west_src[r*WIDTH +: WIDTH]),
            .q   (in_west[r*WIDTH +: WIDTH])
        );
    end

    for (genvar c = 1; c < J; c++) begin : g_north
        skew_line #(.WIDTH(WIDTH), .DEPTH(c)) u_skew (
            .clk (clk),
            .rst (rst),
            .d   (north_src[c*WIDTH +: WIDTH]),
            .q   (in_north[c*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Self-checking bench for gemm_tile_sequencer: cycle model
// plus directed literal pins and randomized jobs.
module tb_gemm_tile_sequencer;

    localparam int W  = 16;
    localparam int AW = 4;
    localparam int NI = 4;
    localparam int NJ = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  k = '0, m_tiles = '0, n_tiles = '0;
    logic          busy, done, rd_en, feed_valid, acc_clear, tile_done;
    logic [AW-1:0] ifmaps_addr, filters_addr;
    logic [NI*W-1:0] ifmaps_dout = '0, in_west;
    logic [NJ*W-1:0] filters_dout = '0, in_north;
    logic [W-1:0]  tile_row, tile_col;

    logic [NI*W-1:0] mem_i [16];
    logic [NJ*W-1:0] mem_f [16];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gemm_tile_sequencer #(
        .WIDTH(W), .ADDR_WIDTH(AW), .I(NI), .J(NJ)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k            (k),
        .m_tiles      (m_tiles),
        .n_tiles      (n_tiles),
        .busy         (busy),
        .done         (done),
        .rd_en        (rd_en),
        .ifmaps_addr  (ifmaps_addr),
        .filters_addr (filters_addr),
        .ifmaps_dout  (ifmaps_dout),
        .filters_dout (filters_dout),
        .in_west      (in_west),
        .in_north     (in_north),
        .feed_valid   (feed_valid),
        .acc_clear    (acc_clear),
        .tile_done    (tile_done),
        .tile_row     (tile_row),
        .tile_col     (tile_col)
    );

    // operand SRAMs: one-cycle read latency, output held otherwise
    always @(posedge clk) begin
        if (rd_en) begin
            ifmaps_dout  <= mem_i[ifmaps_addr];
            filters_dout <= mem_f[filters_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    int unsigned cyc = 0, job_s = 0, rel, per, tot, idx, ph, tr, tc, off;
    int unsigned jk = 0, jm = 0, jn = 0;
    bit          job_on = 0;
    logic        e_busy, e_done, e_rd, e_fv, e_clr, e_td;
    logic [W-1:0]  e_row, e_col;
    logic [AW-1:0] e_ia, e_fa, last_i = '0, last_f = '0;
    logic [NI*W-1:0] lane_w, e_west;
    logic [NJ*W-1:0] lane_n, e_north;
    logic [NI*W-1:0] hw [64];
    logic [NJ*W-1:0] hn [64];

    initial begin
        for (int i = 0; i < 64; i++) begin
            hw[i] = '0;
            hn[i] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            e_busy = 0; e_done = 0; e_rd = 0; e_fv = 0;
            e_clr = 0; e_td = 0; e_row = '0; e_col = '0;
            e_ia = last_i;
            e_fa = last_f;
            if (rst) begin
                job_on = 0;
                e_ia = '0;
                e_fa = '0;
                for (int i = 0; i < 64; i++) begin
                    hw[i] = '0;
                    hn[i] = '0;
                end
            end else if (job_on) begin
                rel = cyc - job_s;
                if (jk == 0 || jm == 0 || jn == 0) begin
                    e_done = (rel == 1);
                end else begin
                    per = jk + NI + NJ + 1;
                    tot = jm * jn;
                    if (rel >= 1 && rel <= tot * per) begin
                        idx = (rel - 1) / per;
                        ph  = (rel - 1) % per;
                        tr  = idx / jn;
                        tc  = idx % jn;
                        e_busy = 1;
                        e_clr  = (ph == 0);
                        e_fv   = (ph >= 1 && ph <= jk);
                        e_rd   = e_clr || (ph >= 1 && ph < jk);
                        e_td   = (ph == per - 1);
                        if (e_td) begin
                            e_row  = W'(tr);
                            e_col  = W'(tc);
                            e_done = (idx == tot - 1);
                        end
                        if (e_rd) begin
                            off  = e_clr ? 0 : ph;
                            e_ia = AW'(tr * jk + off);
                            e_fa = AW'(tc * jk + off);
                        end
                    end
                end
            end
            // data seen this cycle was read at last cycle's address
            lane_w = e_fv ? mem_i[last_i] : '0;
            lane_n = e_fv ? mem_f[last_f] : '0;
            hw[cyc % 64] = lane_w;
            hn[cyc % 64] = lane_n;
            for (int r = 0; r < NI; r++)
                e_west[r*W +: W] = hw[(cyc - r) % 64][r*W +: W];
            for (int c = 0; c < NJ; c++)
                e_north[c*W +: W] = hn[(cyc - c) % 64][c*W +: W];

            chk("ctrl",
                {busy, done, rd_en, feed_valid, acc_clear, tile_done,
                 tile_row, tile_col},
                {e_busy, e_done, e_rd, e_fv, e_clr, e_td, e_row, e_col});
            chk("ifmaps_addr", ifmaps_addr, e_ia);
            chk("filters_addr", filters_addr, e_fa);
            chk("in_west", in_west, e_west);
            chk("in_north", in_north, e_north);

            last_i = e_ia;
            last_f = e_fa;
            if (!rst && start && !e_busy) begin
                job_on = 1;
                job_s  = cyc;
                jk = k;
                jm = m_tiles;
                jn = n_tiles;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input int kv, input int mv, input int nv);
        k       = W'(kv);
        m_tiles = W'(mv);
        n_tiles = W'(nv);
        start   = 1'b1;
        step(1);
        start   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while (done !== 1'b1 && c < budget) begin
            step(1);
            c++;
        end
        chk(name, done, 1'b1);
    endtask

    initial begin
        int ia_lit [4];
        int fa_lit [4];
        int wr_lit [5];
        int rows [4];
        int cols [4];
        logic [NI*W-1:0] w0;
        bit got_done;
        int c;

        ia_lit = '{0, 0, 2, 2};
        fa_lit = '{0, 2, 0, 2};
        rows   = '{0, 0, 1, 1};
        cols   = '{0, 1, 0, 1};
        wr_lit = '{15, 0, 1, 2, 3};
        for (int i = 0; i < 16; i++) begin
            mem_i[i] = {$urandom, $urandom};
            mem_f[i] = {$urandom, $urandom};
        end

        step(3);
        chk("reset busy", busy, 1'b0);
        chk("reset west", in_west, '0);
        rst = 1'b0;
        step(2);

        // single tile, K=3
        launch(3, 1, 1);
        chk("t1 acc_clear", acc_clear, 1'b1);
        chk("t1 addr rel1", ifmaps_addr, 0);
        step(1);
        chk("t1 fv rel2", feed_valid, 1'b1);
        chk("t1 addr rel2", ifmaps_addr, 1);
        step(1);
        chk("t1 addr rel3", ifmaps_addr, 2);
        step(1);
        chk("t1 rd_en rel4", rd_en, 1'b0);
        step(1);
        w0 = mem_i[0];
        chk("t1 west3 rel5", in_west[3*W +: W], w0[3*W +: W]);
        step(7);
        chk("t1 tile_done rel12", tile_done, 1'b1);
        chk("t1 done rel12", done, 1'b1);
        step(1);
        chk("t1 busy rel13", busy, 1'b0);
        step(2);

        // 2x2 tiles, K=2, with an ignored start and config change mid-job
        launch(2, 2, 2);
        for (int t = 0; t < 4; t++) begin
            chk("t2 acc_clear", acc_clear, 1'b1);
            chk("t2 ifmaps base", ifmaps_addr, ia_lit[t]);
            chk("t2 filters base", filters_addr, fa_lit[t]);
            if (t == 0) begin
                step(2);
                start = 1'b1;
                k     = 9;
                step(1);
                start = 1'b0;
                k     = 2;
                step(7);
            end else begin
                step(10);
            end
            chk("t2 tile_done", tile_done, 1'b1);
            chk("t2 tile_row", tile_row, rows[t]);
            chk("t2 tile_col", tile_col, cols[t]);
            chk("t2 done", done, t == 3);
            step(1);
        end
        chk("t2 busy after", busy, 1'b0);
        step(1);

        // zero config, then a normal K=1 job straight after
        launch(0, 3, 2);
        chk("t3 done rel1", done, 1'b1);
        chk("t3 busy rel1", busy, 1'b0);
        step(1);
        chk("t3 done rel2", done, 1'b0);
        launch(1, 1, 1);
        chk("t4 rd_en rel1", rd_en, 1'b1);
        step(1);
        chk("t4 rd_en rel2", rd_en, 1'b0);
        chk("t4 fv rel2", feed_valid, 1'b1);
        step(8);
        chk("t4 done rel10", done, 1'b1);
        step(2);

        // reset during FEED
        launch(4, 1, 2);
        step(2);
        rst = 1'b1;
        #1;
        chk("t5 busy", busy, 1'b0);
        chk("t5 feed_valid", feed_valid, 1'b0);
        chk("t5 west", in_west, '0);
        chk("t5 north", in_north, '0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("t5 no done", done, 1'b0);
        launch(2, 1, 1);
        wait_done("t5 cold job done", 40);
        step(2);

        // address wrap at 4 bits
        launch(5, 4, 1);
        step(42);
        for (int i = 0; i < 5; i++) begin
            chk("t6 wrap addr", ifmaps_addr, wr_lit[i]);
            step(1);
        end
        wait_done("t6 done", 80);
        step(2);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            launch($urandom_range(0, 4), $urandom_range(1, 3),
                   $urandom_range(1, 3));
            got_done = 0;
            c = 0;
            while (c < 300) begin
                if (done === 1'b1) begin
                    got_done = 1;
                    break;
                end
                if (j == 6 && c == 6) break;
                start   = busy && ($urandom_range(0, 7) == 0);
                k       = W'($urandom);
                m_tiles = W'($urandom);
                n_tiles = W'($urandom);
                step(1);
                start = 1'b0;
                c++;
            end
            start = 1'b0;
            if (j == 6) begin
                rst = 1'b1;
                step(2);
                rst = 1'b0;
            end else begin
                chk("rand job done", got_done, 1'b1);
            end
            step(2);
        end

        step(3);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
